// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin sharing of one combinational ALU between two requesters
module alu_share_arbiter #(
   parameter int W  = 32,
   parameter int TW = 4,
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req0_valid,
   output logic          req0_ready,
   input  logic [W-1:0]  req0_src_a,
   input  logic [W-1:0]  req0_src_b,
   input  logic [3:0]    req0_ctrl,
   input  logic [TW-1:0] req0_tag,
   input  logic          req1_valid,
   output logic          req1_ready,
   input  logic [W-1:0]  req1_src_a,
   input  logic [W-1:0]  req1_src_b,
   input  logic [3:0]    req1_ctrl,
   input  logic [TW-1:0] req1_tag,
   output logic [W-1:0]  alu_src_a,
   output logic [W-1:0]  alu_src_b,
   output logic [3:0]    alu_ctrl,
   input  logic [W-1:0]  alu_result,
   input  logic          alu_zero,
   input  logic          alu_neg,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic          rsp_id,
   output logic [TW-1:0] rsp_tag,
   output logic [W-1:0]  rsp_result,
   output logic          rsp_zero,
   output logic          rsp_neg,
   output logic [CW-1:0] grant_cnt0,
   output logic [CW-1:0] grant_cnt1
);

   // The response slot is the only state machine: EMPTY or FULL.
   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_t;

   slot_t state, state_n;
   logic  last;       // index of the most recent grant; the other side wins a tie
   logic  slot_free;
   logic  gnt;
   logic  gnt_id;
   logic  [TW-1:0] gnt_tag;

   assign rsp_valid = (state == FULL);

   // Slot state register; a reset drops any held response.
   always_ff @(posedge clk) begin
      if (rst) state <= EMPTY;
      else     state <= state_n;
   end

   // Grant selection, ALU operand steering and next slot state.
   always_comb begin
      gnt        = 1'b0;
      gnt_id     = 1'b0;
      gnt_tag    = '0;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      alu_src_a  = '0;
      alu_src_b  = '0;
      alu_ctrl   = 4'b0000;
      state_n    = state;
      slot_free  = (state == EMPTY) || rsp_ready;

      if (slot_free) begin
         if (req0_valid && req1_valid) begin
            gnt    = 1'b1;
            gnt_id = ~last;
         end else if (req0_valid) begin
            gnt    = 1'b1;
            gnt_id = 1'b0;
         end else if (req1_valid) begin
            gnt    = 1'b1;
            gnt_id = 1'b1;
         end
      end

      if (gnt) begin
         if (gnt_id) begin
            req1_ready = 1'b1;
            alu_src_a  = req1_src_a;
            alu_src_b  = req1_src_b;
            alu_ctrl   = req1_ctrl;
            gnt_tag    = req1_tag;
         end else begin
            req0_ready = 1'b1;
            alu_src_a  = req0_src_a;
            alu_src_b  = req0_src_b;
            alu_ctrl   = req0_ctrl;
            gnt_tag    = req0_tag;
         end
      end

      case (state)
         EMPTY:   if (gnt) state_n = FULL;
         FULL:    if (rsp_ready && !gnt) state_n = EMPTY;
         default: state_n = EMPTY;
      endcase
   end

   // Capture the ALU outcome on a grant; fields hold on drain and under backpressure.
   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_id     <= 1'b0;
         rsp_tag    <= '0;
         rsp_result <= '0;
         rsp_zero   <= 1'b0;
         rsp_neg    <= 1'b0;
         last       <= 1'b1;
      end else if (gnt) begin
         rsp_id     <= gnt_id;
         rsp_tag    <= gnt_tag;
         rsp_result <= alu_result;
         rsp_zero   <= alu_zero;
         rsp_neg    <= alu_neg;
         last       <= gnt_id;
      end
   end

   // Saturating grant counters for performance monitoring.
   always_ff @(posedge clk) begin
      if (rst) begin
         grant_cnt0 <= '0;
         grant_cnt1 <= '0;
      end else if (gnt) begin
         if (!gnt_id && (grant_cnt0 != {CW{1'b1}})) grant_cnt0 <= grant_cnt0 + CW'(1);
         if (gnt_id  && (grant_cnt1 != {CW{1'b1}})) grant_cnt1 <= grant_cnt1 + CW'(1);
      end
   end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - directed table-driven bench for alu_share_arbiter
module tb_alu_share_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req0_valid, req1_valid, req0_ready, req1_ready;
   logic [31:0] req0_src_a, req0_src_b, req1_src_a, req1_src_b;
   logic [3:0]  req0_ctrl, req1_ctrl, req0_tag, req1_tag;
   logic [31:0] alu_src_a, alu_src_b, alu_result;
   logic [3:0]  alu_ctrl;
   logic        alu_zero, alu_neg;
   logic        rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_neg;
   logic [3:0]  rsp_tag;
   logic [31:0] rsp_result;
   logic [15:0] grant_cnt0, grant_cnt1;

   // second instance with narrow counters for the saturation check
   logic        s_req0_valid, s_req0_ready, s_req1_ready, s_rsp_valid, s_rsp_id, s_rsp_zero, s_rsp_neg;
   logic [31:0] s_alu_src_a, s_alu_src_b, s_rsp_result;
   logic [3:0]  s_alu_ctrl, s_rsp_tag;
   logic [1:0]  s_cnt0, s_cnt1;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   // reference ALU attached to the shared port
   always_comb begin
      case (alu_ctrl)
         4'd0:    alu_result = alu_src_a + alu_src_b;
         4'd1:    alu_result = alu_src_a - alu_src_b;
         4'd2:    alu_result = alu_src_a & alu_src_b;
         4'd3:    alu_result = alu_src_a | alu_src_b;
         4'd4:    alu_result = alu_src_a ^ alu_src_b;
         4'd5:    alu_result = {31'd0, $signed(alu_src_a) < $signed(alu_src_b)};
         4'd6:    alu_result = {31'd0, alu_src_a < alu_src_b};
         4'd7:    alu_result = alu_src_a << alu_src_b[4:0];
         4'd8:    alu_result = alu_src_a >> alu_src_b[4:0];
         4'd9:    alu_result = $signed(alu_src_a) >>> alu_src_b[4:0];
         default: alu_result = 32'd0;
      endcase
      alu_zero = (alu_result == 32'd0);
      alu_neg  = alu_result[31];
   end

   alu_share_arbiter dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_src_a(req0_src_a),
      .req0_src_b(req0_src_b), .req0_ctrl(req0_ctrl), .req0_tag(req0_tag),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_src_a(req1_src_a),
      .req1_src_b(req1_src_b), .req1_ctrl(req1_ctrl), .req1_tag(req1_tag),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl),
      .alu_result(alu_result), .alu_zero(alu_zero), .alu_neg(alu_neg),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_tag(rsp_tag),
      .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_neg(rsp_neg),
      .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
   );

   alu_share_arbiter #(.W(32), .TW(4), .CW(2)) dut_sat (
      .clk(clk), .rst(rst),
      .req0_valid(s_req0_valid), .req0_ready(s_req0_ready), .req0_src_a(32'd1),
      .req0_src_b(32'd2), .req0_ctrl(4'd0), .req0_tag(4'd1),
      .req1_valid(1'b0), .req1_ready(s_req1_ready), .req1_src_a(32'd0),
      .req1_src_b(32'd0), .req1_ctrl(4'd0), .req1_tag(4'd0),
      .alu_src_a(s_alu_src_a), .alu_src_b(s_alu_src_b), .alu_ctrl(s_alu_ctrl),
      .alu_result(32'd3), .alu_zero(1'b0), .alu_neg(1'b0),
      .rsp_valid(s_rsp_valid), .rsp_ready(1'b1), .rsp_id(s_rsp_id), .rsp_tag(s_rsp_tag),
      .rsp_result(s_rsp_result), .rsp_zero(s_rsp_zero), .rsp_neg(s_rsp_neg),
      .grant_cnt0(s_cnt0), .grant_cnt1(s_cnt1)
   );

   typedef struct {
      logic v0; logic [31:0] a0, b0; logic [3:0] c0, t0;
      logic v1; logic [31:0] a1, b1; logic [3:0] c1, t1;
      logic rr;
      logic e_r0, e_r1; logic [31:0] e_alu_a; logic [3:0] e_ctrl;
      logic e_val, e_id; logic [3:0] e_tag; logic [31:0] e_res; logic e_z, e_n;
      logic [15:0] e_c0, e_c1;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_rsp(input string pfx, input logic v, input logic id, input logic [3:0] tag,
                          input logic [31:0] res, input logic z, input logic n);
      chk({pfx, " rsp_valid"},  {31'd0, rsp_valid}, {31'd0, v});
      chk({pfx, " rsp_id"},     {31'd0, rsp_id},    {31'd0, id});
      chk({pfx, " rsp_tag"},    {28'd0, rsp_tag},   {28'd0, tag});
      chk({pfx, " rsp_result"}, rsp_result,         res);
      chk({pfx, " rsp_zero"},   {31'd0, rsp_zero},  {31'd0, z});
      chk({pfx, " rsp_neg"},    {31'd0, rsp_neg},   {31'd0, n});
   endtask

   initial begin
      logic [1:0] sat_exp[5];
      sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

      // v0 a0 b0 c0 t0 | v1 a1 b1 c1 t1 | rr | r0 r1 alu_a ctrl | val id tag res z n | c0 c1
      vecs[0] = '{1, 32'd5, 32'd3, 4'd0, 4'd2, 0, 32'd0, 32'd0, 4'd0, 4'd0, 1,
                  1, 0, 32'd5, 4'd0, 1, 0, 4'd2, 32'd8, 0, 0, 16'd1, 16'd0};
      vecs[1] = '{0, 32'd0, 32'd0, 4'd0, 4'd0, 1, 32'hFFFF_FFFF, 32'd1, 4'hF, 4'd7, 1,
                  0, 1, 32'hFFFF_FFFF, 4'hF, 1, 1, 4'd7, 32'd0, 1, 0, 16'd1, 16'd1};
      vecs[2] = '{1, 32'd7, 32'd7, 4'd1, 4'd3, 1, 32'd1, 32'hFFFF_FFFF, 4'd6, 4'd5, 1,
                  1, 0, 32'd7, 4'd1, 1, 0, 4'd3, 32'd0, 1, 0, 16'd2, 16'd1};
      vecs[3] = '{1, 32'd7, 32'd7, 4'd1, 4'd3, 1, 32'd1, 32'hFFFF_FFFF, 4'd6, 4'd5, 1,
                  0, 1, 32'd1, 4'd6, 1, 1, 4'd5, 32'd1, 0, 0, 16'd2, 16'd2};
      vecs[4] = '{1, 32'd7, 32'd7, 4'd1, 4'd3, 1, 32'd1, 32'hFFFF_FFFF, 4'd6, 4'd5, 1,
                  1, 0, 32'd7, 4'd1, 1, 0, 4'd3, 32'd0, 1, 0, 16'd3, 16'd2};
      vecs[5] = '{1, 32'd7, 32'd7, 4'd1, 4'd3, 1, 32'd1, 32'hFFFF_FFFF, 4'd6, 4'd5, 1,
                  0, 1, 32'd1, 4'd6, 1, 1, 4'd5, 32'd1, 0, 0, 16'd3, 16'd3};
      vecs[6] = '{0, 32'd0, 32'd0, 4'd0, 4'd0, 0, 32'd0, 32'd0, 4'd0, 4'd0, 1,
                  0, 0, 32'd0, 4'd0, 0, 1, 4'd5, 32'd1, 0, 0, 16'd3, 16'd3};
      vecs[7] = '{1, 32'd3, 32'd5, 4'd1, 4'd1, 0, 32'd0, 32'd0, 4'd0, 4'd0, 1,
                  1, 0, 32'd3, 4'd1, 1, 0, 4'd1, 32'hFFFF_FFFE, 0, 1, 16'd4, 16'd3};

      req0_valid = 0; req1_valid = 0; rsp_ready = 0; s_req0_valid = 0;
      req0_src_a = 0; req0_src_b = 0; req0_ctrl = 0; req0_tag = 0;
      req1_src_a = 0; req1_src_b = 0; req1_ctrl = 0; req1_tag = 0;

      repeat (2) @(posedge clk);
      #1;
      chk_rsp("reset", 0, 0, 4'd0, 32'd0, 0, 0);
      chk("reset grant_cnt0", {16'd0, grant_cnt0}, 32'd0);
      chk("reset grant_cnt1", {16'd0, grant_cnt1}, 32'd0);

      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         rst = 0;
         req0_valid = vecs[i].v0; req0_src_a = vecs[i].a0; req0_src_b = vecs[i].b0;
         req0_ctrl = vecs[i].c0; req0_tag = vecs[i].t0;
         req1_valid = vecs[i].v1; req1_src_a = vecs[i].a1; req1_src_b = vecs[i].b1;
         req1_ctrl = vecs[i].c1; req1_tag = vecs[i].t1;
         rsp_ready = vecs[i].rr;
         #1;
         chk($sformatf("v%0d req0_ready", i), {31'd0, req0_ready}, {31'd0, vecs[i].e_r0});
         chk($sformatf("v%0d req1_ready", i), {31'd0, req1_ready}, {31'd0, vecs[i].e_r1});
         chk($sformatf("v%0d alu_src_a", i), alu_src_a, vecs[i].e_alu_a);
         chk($sformatf("v%0d alu_ctrl", i), {28'd0, alu_ctrl}, {28'd0, vecs[i].e_ctrl});
         @(posedge clk);
         #1;
         chk_rsp($sformatf("v%0d", i), vecs[i].e_val, vecs[i].e_id, vecs[i].e_tag,
                 vecs[i].e_res, vecs[i].e_z, vecs[i].e_n);
         chk($sformatf("v%0d grant_cnt0", i), {16'd0, grant_cnt0}, {16'd0, vecs[i].e_c0});
         chk($sformatf("v%0d grant_cnt1", i), {16'd0, grant_cnt1}, {16'd0, vecs[i].e_c1});
      end

      // backpressure: slot full, req1 waits three cycles with everything frozen
      @(negedge clk);
      req0_valid = 0;
      req1_valid = 1; req1_src_a = 32'd9; req1_src_b = 32'd4; req1_ctrl = 4'd0; req1_tag = 4'd6;
      rsp_ready = 0;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk($sformatf("bp%0d req1_ready", k), {31'd0, req1_ready}, 32'd0);
         @(posedge clk);
         #1;
         chk_rsp($sformatf("bp%0d", k), 1, 0, 4'd1, 32'hFFFF_FFFE, 0, 1);
         chk($sformatf("bp%0d grant_cnt1", k), {16'd0, grant_cnt1}, 32'd3);
         @(negedge clk);
      end
      rsp_ready = 1;
      #1;
      chk("bp release req1_ready", {31'd0, req1_ready}, 32'd1);
      @(posedge clk);
      #1;
      chk_rsp("bp release", 1, 1, 4'd6, 32'd13, 0, 0);
      chk("bp release grant_cnt1", {16'd0, grant_cnt1}, 32'd4);
      @(negedge clk);
      req1_valid = 0;
      @(posedge clk);
      #1;
      chk("drain rsp_valid", {31'd0, rsp_valid}, 32'd0);

      // reset while a response is held under backpressure
      @(negedge clk);
      req0_valid = 1; req0_src_a = 32'd1; req0_src_b = 32'd1; req0_ctrl = 4'd0; req0_tag = 4'd4;
      rsp_ready = 0;
      @(posedge clk);
      #1;
      chk("pre-reset rsp_valid", {31'd0, rsp_valid}, 32'd1);
      @(negedge clk);
      req0_valid = 0;
      rst = 1;
      @(posedge clk);
      #1;
      chk_rsp("mid reset", 0, 0, 4'd0, 32'd0, 0, 0);
      chk("mid reset grant_cnt0", {16'd0, grant_cnt0}, 32'd0);
      chk("mid reset grant_cnt1", {16'd0, grant_cnt1}, 32'd0);
      @(negedge clk);
      rst = 0;
      req0_valid = 1; req0_src_a = 32'd7; req0_src_b = 32'd7; req0_ctrl = 4'd1; req0_tag = 4'd3;
      req1_valid = 1; req1_src_a = 32'd1; req1_src_b = 32'hFFFF_FFFF; req1_ctrl = 4'd6; req1_tag = 4'd5;
      rsp_ready = 1;
      #1;
      chk("post reset req0_ready", {31'd0, req0_ready}, 32'd1);
      chk("post reset req1_ready", {31'd0, req1_ready}, 32'd0);
      @(posedge clk);
      #1;
      chk_rsp("post reset", 1, 0, 4'd3, 32'd0, 1, 0);

      // saturation on the 2-bit counter instance
      @(negedge clk);
      req0_valid = 0; req1_valid = 0;
      s_req0_valid = 1;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         #1;
         chk($sformatf("sat%0d grant_cnt0", k), {30'd0, s_cnt0}, {30'd0, sat_exp[k]});
      end
      @(negedge clk);
      s_req0_valid = 0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
